// File: rtl/cpu54_muldiv_sequencer_if.sv
// Request/result bundle between the multicycle controller and the mul/div sequencer.
// The controller drives requests and MTHI/MTLO writes; the sequencer owns HI/LO.
interface cpu54_muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  hi_out, lo_out, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output hi_out, lo_out, busy, done, div_by_zero
  );
endinterface

// File: rtl/cpu54_muldiv_sequencer.sv
// Iterative 32-cycle multiply / restoring divide with HI/LO ownership and MTHI/MTLO writes.
// Signed ops run on magnitudes; the sign fix-up happens in the single FIX cycle.
module cpu54_muldiv_sequencer (
  input logic                    clock_in,
  input logic                    reset_signal,
  cpu54_muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rs_q, rs_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_sub;
  logic        div_ge;
  logic [63:0] prod_neg;

  always_comb begin
    rs_neg   = bus.op[0] & bus.rs_val[31];
    rt_neg   = bus.op[0] & bus.rt_val[31];
    rs_mag   = rs_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    rt_mag   = rt_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    // Top 33 bits of {remainder, quotient} << 1
    div_sh   = acc_q[63:31];
    div_ge   = div_sh >= {1'b0, b_q};
    div_sub  = div_sh - {1'b0, b_q};
    prod_neg = 64'd0 - acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    b_d       = b_q;
    rs_d      = rs_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d      = bus.op;
          rs_d      = bus.rs_val;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          cnt_d     = 5'd0;
          state_d   = StRun;
          if (bus.op[1]) begin
            acc_d = {32'd0, rs_mag};
            b_d   = rt_mag;
          end else begin
            acc_d = {32'd0, rt_mag};
            b_d   = rs_mag;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      StRun: begin
        if (op_q[1]) begin
          acc_d = div_ge ? {div_sub[31:0], acc_q[30:0], 1'b1}
                         : {div_sh[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (!op_q[1]) begin
          {hi_d, lo_d} = (op_q[0] && neg_res_q) ? prod_neg : acc_q;
        end else if (b_q == 32'd0) begin
          hi_d  = rs_q;
          lo_d  = 32'hFFFF_FFFF;
          dbz_d = 1'b1;
        end else begin
          lo_d = (op_q[0] && neg_res_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
          hi_d = (op_q[0] && neg_rem_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_signal) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      acc_q     <= 64'd0;
      b_q       <= 32'd0;
      rs_q      <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      rs_q      <= rs_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_cpu54_muldiv_sequencer.sv
// Directed-vector bench for the mul/div sequencer: table of operations plus
// hand sequences for MTHI/MTLO, busy-time drops, back-to-back and mid-run reset.
module tb_cpu54_muldiv_sequencer;
  logic clock_in;
  logic reset_signal;

  cpu54_muldiv_sequencer_if bus ();

  cpu54_muldiv_sequencer dut (
    .clock_in     (clock_in),
    .reset_signal (reset_signal),
    .bus          (bus)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Issues a request at the next edge, scrambles operands afterwards, waits for done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy1);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    tick();
    bus.start  = 1'b0;
    bus.rs_val = ~a;
    bus.rt_val = ~b;
    bus.op     = ~op;
    busy1      = bus.busy;
    lat        = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    logic       busy1;
    logic       seen_done;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b10, 32'h0000_0064, 32'h0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[6]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    vecs[7]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFD, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b00, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1'b0};
    vecs[10] = '{2'b01, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 1'b0};

    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    reset_signal = 1'b1;
    tick();
    tick();
    reset_signal = 1'b0;

    check("reset_hi",   bus.hi_out, 0);
    check("reset_lo",   bus.lo_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_dbz",  bus.div_by_zero, 0);

    for (int v = 0; v < 12; v++) begin
      do_op(vecs[v].op, vecs[v].a, vecs[v].b, lat, busy1);
      check($sformatf("v%0d_busy_start", v), busy1, 1);
      check($sformatf("v%0d_latency", v), lat, 33);
      check($sformatf("v%0d_hi", v), bus.hi_out, vecs[v].hi);
      check($sformatf("v%0d_lo", v), bus.lo_out, vecs[v].lo);
      check($sformatf("v%0d_dbz", v), bus.div_by_zero, vecs[v].dz);
      check($sformatf("v%0d_busy_done", v), bus.busy, 0);
      tick();
      check($sformatf("v%0d_done_pulse", v), bus.done, 0);
    end

    // MTHI / MTLO while idle
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    tick();
    bus.hi_we = 1'b0;
    check("mthi_hi", bus.hi_out, 32'h1234);
    check("mthi_lo_kept", bus.lo_out, 32'hFFFF_FFFF);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_0001;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mt_both_hi", bus.hi_out, 32'hCAFE_0001);
    check("mt_both_lo", bus.lo_out, 32'hCAFE_0001);

    // start together with hi_we: start wins, write dropped
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    bus.hi_we = 1'b1; bus.wdata = 32'h5555;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("start_wins_hi", bus.hi_out, 32'hCAFE_0001);
    check("start_wins_busy", bus.busy, 1);
    // Second start + MTHI at RUN cycle 10 must be ignored
    for (int i = 0; i < 9; i++) tick();
    bus.start = 1'b1; bus.op = 2'b10; bus.rs_val = 32'd99; bus.rt_val = 32'd4;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("busy_mthi_dropped", bus.hi_out, 32'hCAFE_0001);
    lat = 0;
    for (int i = 11; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("busy_ignore_latency", lat, 33);
    check("busy_ignore_hi", bus.hi_out, 0);
    check("busy_ignore_lo", bus.lo_out, 15);

    // Back-to-back: start issued in the done cycle
    do_op(2'b10, 32'd50, 32'd6, lat, busy1);
    check("b2b_first_lo", bus.lo_out, 8);
    do_op(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, busy1);
    check("b2b_busy", busy1, 1);
    check("b2b_latency", lat, 33);
    check("b2b_hi", bus.hi_out, 0);
    check("b2b_lo", bus.lo_out, 6);

    // Reset at RUN cycle 20 aborts without commit or done
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    reset_signal = 1'b1;
    tick();
    reset_signal = 1'b0;
    check("rst_mid_hi",   bus.hi_out, 0);
    check("rst_mid_lo",   bus.lo_out, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("rst_mid_no_done", seen_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
